// File: rtl/tristate_line_rx.sv
// rtl/tristate_line_rx.sv - tristate serial line receiver with turnaround parity ack
// Deserializes MSB-first words, then takes the line for one cycle to return even parity.
module tristate_line_rx #(
  parameter int WIDTH = 8,
  parameter int TURN  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             data_in,
  output logic [WIDTH-1:0] byte_out,
  output logic             valid_out,
  output logic             err_out,
  output logic             ack_out,
  output logic             ack_oe_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0] TURN_LAST = 4'((TURN == 0) ? 0 : TURN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_TURN,
    S_ACK,
    S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic [3:0]       tcnt_q, tcnt_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             ack_q, ack_d;
  logic             ack_oe_q, ack_oe_d;

  logic [WIDTH-1:0] word;
  logic             word_done;

  assign word      = {sr_q, data_in};
  assign word_done = (state_q == S_SHIFT) && a_in && (bcnt_q == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
      sr_q     <= '0;
      par_q    <= 1'b0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      ack_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      tcnt_q   <= tcnt_d;
      sr_q     <= sr_d;
      par_q    <= par_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      ack_oe_q <= ack_oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (a_in) state_d = S_SHIFT;
      S_SHIFT: begin
        if (!a_in)          state_d = S_IDLE;
        else if (word_done) state_d = (TURN == 0) ? S_ACK : S_TURN;
      end
      S_TURN: begin
        if (a_in)                       state_d = S_DRAIN;
        else if (tcnt_q == TURN_LAST)   state_d = S_ACK;
      end
      // a_in high on the edge leaving ACK is contention, including an early next frame
      S_ACK:   state_d = a_in ? S_DRAIN : S_IDLE;
      S_DRAIN: if (!a_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bcnt_d   = bcnt_q;
    tcnt_d   = tcnt_q;
    sr_d     = sr_q;
    par_d    = par_q;
    byte_d   = byte_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    ack_d    = 1'b0;
    ack_oe_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (a_in) begin
          sr_d    = '0;
          sr_d[0] = data_in;
          bcnt_d  = CW'(1);
        end
      end
      S_SHIFT: begin
        if (!a_in) begin
          err_d  = 1'b1;
          bcnt_d = '0;
        end else if (word_done) begin
          byte_d  = word;
          valid_d = 1'b1;
          par_d   = ^word;
          bcnt_d  = '0;
          tcnt_d  = '0;
        end else begin
          sr_d   = word[WIDTH-2:0];
          bcnt_d = bcnt_q + CW'(1);
        end
      end
      S_TURN: begin
        if (a_in)                      err_d  = 1'b1;
        else if (tcnt_q != TURN_LAST)  tcnt_d = tcnt_q + 4'd1;
      end
      S_ACK:   err_d = a_in;
      default: ;
    endcase
    // With TURN=0 the parity is taken straight from the completing word
    if (state_d == S_ACK) begin
      ack_oe_d = 1'b1;
      ack_d    = (state_q == S_SHIFT) ? ^word : par_q;
    end
  end

  assign byte_out   = byte_q;
  assign valid_out  = valid_q;
  assign err_out    = err_q;
  assign ack_out    = ack_q;
  assign ack_oe_out = ack_oe_q;

endmodule
